// File: rtl/rv32i_dbg_trigger_pkg.sv
// Shared constants and types for the RV32I debug trigger unit.
// Watchpoint modes are enabled by defining RV32I_DBG_WATCHPOINT_EN.
package rv32i_dbg_trigger_pkg;

    localparam logic [11:0] DBG_BP_BASE_ADDR = 12'h100;
    localparam int          DBG_BP_STRIDE    = 8;

    // Register addresses of the original two-breakpoint window, kept for older callers.
    localparam logic [11:0] DBG_BP0_ADDR = DBG_BP_BASE_ADDR;
    localparam logic [11:0] DBG_BP0_CTRL = DBG_BP_BASE_ADDR + 12'h004;
    localparam logic [11:0] DBG_BP1_ADDR = DBG_BP_BASE_ADDR + 12'(DBG_BP_STRIDE);
    localparam logic [11:0] DBG_BP1_CTRL = DBG_BP1_ADDR + 12'h004;

    typedef enum logic [3:0] {
        HALT_NONE       = 4'b0000,
        HALT_BREAKPOINT = 4'b0010
    } halt_cause_e;

    typedef enum logic [1:0] {
        TRIG_EXEC       = 2'b00,
        TRIG_EXEC_NAPOT = 2'b01,
        TRIG_WATCH_LS   = 2'b10,
        TRIG_WATCH_ST   = 2'b11
    } trig_mode_e;

    typedef struct packed {
        logic       hit;       // [31]
        logic [6:0] rsvd3;     // [30:24]
        logic [7:0] thresh;    // [23:16]
        logic [2:0] rsvd2;     // [15:13]
        logic [4:0] napot_k;   // [12:8]
        logic [4:0] rsvd1;     // [7:3]
        trig_mode_e mode;      // [2:1]
        logic       enable;    // [0]
    } trig_ctrl_t;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_PEND = 1'b1
    } req_state_e;

endpackage

// File: rtl/rv32i_dbg_trigger_if.sv
// APB slave bus carrying the breakpoint register window.
interface rv32i_dbg_trigger_if;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/rv32i_trig_match.sv
// One trigger: ADDR/CTRL registers, hit counter and match/fire logic.
// Watch modes exist only when RV32I_DBG_WATCHPOINT_EN is defined.
module rv32i_trig_match
    import rv32i_dbg_trigger_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        addr_we_i,
    input  logic        ctrl_we_i,
    input  logic [31:0] wdata_i,
    input  logic        match_en_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_write_i,
    output logic        fire_o,
    output logic [31:0] addr_o,
    output logic [31:0] ctrl_o
);

    localparam logic [CNT_WIDTH:0] CNT_ONE = (CNT_WIDTH + 1)'(1);

    logic [31:0]          addr_q,    addr_d;
    logic                 enable_q,  enable_d;
    trig_mode_e           mode_q,    mode_d;
    logic [4:0]           napot_k_q, napot_k_d;
    logic [CNT_WIDTH-1:0] thresh_q,  thresh_d;
    logic                 hit_q,     hit_d;
    logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;

    logic [31:0]          napot_mask;
    logic                 cond;
    logic                 match;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic                 reached;
    logic                 unused_bits;
    trig_ctrl_t           ctrl_rd;

    assign napot_mask = 32'hFFFF_FFFF << napot_k_q;

    always_comb begin
        cond = 1'b0;
        case (mode_q)
            TRIG_EXEC:       cond = fetch_valid_i && (fetch_pc_i == addr_q);
            TRIG_EXEC_NAPOT: cond = fetch_valid_i && (((fetch_pc_i ^ addr_q) & napot_mask) == 32'h0);
`ifdef RV32I_DBG_WATCHPOINT_EN
            TRIG_WATCH_LS:   cond = mem_valid_i && (mem_addr_i == addr_q);
            TRIG_WATCH_ST:   cond = mem_valid_i && mem_write_i && (mem_addr_i == addr_q);
`endif
            default:         cond = 1'b0;
        endcase
    end

`ifdef RV32I_DBG_WATCHPOINT_EN
    assign unused_bits = ^wdata_i;
`else
    assign unused_bits = ^{wdata_i, mem_valid_i, mem_addr_i, mem_write_i};
`endif

    assign match   = enable_q && match_en_i && cond;
    assign cnt_inc = {1'b0, cnt_q} + CNT_ONE;
    assign reached = cnt_inc >= {1'b0, thresh_q};
    // A CTRL write in the same cycle overrides the fire entirely.
    assign fire_o  = match && reached && !ctrl_we_i;

    always_comb begin
        addr_d    = addr_q;
        enable_d  = enable_q;
        mode_d    = mode_q;
        napot_k_d = napot_k_q;
        thresh_d  = thresh_q;
        hit_d     = hit_q;
        cnt_d     = cnt_q;
        if (addr_we_i) begin
            addr_d = wdata_i;
        end
        if (ctrl_we_i) begin
            enable_d  = wdata_i[0];
`ifdef RV32I_DBG_WATCHPOINT_EN
            mode_d    = trig_mode_e'(wdata_i[2:1]);
`else
            mode_d    = trig_mode_e'({1'b0, wdata_i[1]});
`endif
            napot_k_d = wdata_i[12:8];
            thresh_d  = wdata_i[16 +: CNT_WIDTH];
            hit_d     = hit_q & ~wdata_i[31];
            cnt_d     = '0;
        end else if (match) begin
            if (reached) begin
                hit_d = 1'b1;
                cnt_d = '0;
            end else if (!(&cnt_q)) begin
                cnt_d = cnt_inc[CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            enable_q  <= 1'b0;
            mode_q    <= TRIG_EXEC;
            napot_k_q <= '0;
            thresh_q  <= '0;
            hit_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            addr_q    <= addr_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            napot_k_q <= napot_k_d;
            thresh_q  <= thresh_d;
            hit_q     <= hit_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        ctrl_rd         = '0;
        ctrl_rd.enable  = enable_q;
        ctrl_rd.mode    = mode_q;
        ctrl_rd.napot_k = napot_k_q;
        ctrl_rd.thresh  = 8'(thresh_q);
        ctrl_rd.hit     = hit_q;
    end

    assign addr_o = addr_q;
    assign ctrl_o = ctrl_rd;

endmodule

// File: rtl/rv32i_dbg_trigger.sv
// Debug trigger unit top: APB decode, trigger array, priority encode, halt request FSM.
// Define RV32I_DBG_WATCHPOINT_EN to enable the data watchpoint modes.
module rv32i_dbg_trigger
    import rv32i_dbg_trigger_pkg::*;
#(
    parameter int NUM_TRIG  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv32i_dbg_trigger_if.slave   apb,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_pc,
    input  logic                 mem_valid,
    input  logic [31:0]          mem_addr,
    input  logic                 mem_write,
    input  logic                 core_halted,
    input  logic                 halt_ack,
    output logic                 bp_halt_req,
    output logic [3:0]           bp_halt_cause,
    output logic [2:0]           bp_hit_idx
);

    localparam logic [11:0] WIN_END = DBG_BP_BASE_ADDR + 12'(DBG_BP_STRIDE * NUM_TRIG);

    logic                access;
    logic                in_range;
    logic                wr_en;
    logic [11:0]         offset;
    logic [2:0]          sel_idx;
    logic                sel_ctrl;
    logic                unused_offset;
    logic [31:0]         rd_word;
    logic                match_en;

    logic [NUM_TRIG-1:0] addr_we;
    logic [NUM_TRIG-1:0] ctrl_we;
    logic [NUM_TRIG-1:0] fire;
    logic [31:0]         trig_addr [NUM_TRIG];
    logic [31:0]         trig_ctrl [NUM_TRIG];
    logic [2:0]          fire_idx;

    req_state_e          state_q, state_d;
    logic [2:0]          hit_idx_q, hit_idx_d;

    assign access        = apb.psel && apb.penable;
    assign in_range      = (apb.paddr >= DBG_BP_BASE_ADDR) && (apb.paddr < WIN_END);
    assign wr_en         = access && apb.pwrite && in_range;
    assign offset        = apb.paddr - DBG_BP_BASE_ADDR;
    assign sel_idx       = offset[5:3];
    assign sel_ctrl      = offset[2];
    assign unused_offset = ^{offset[11:6], offset[1:0]};

    // Matching stops once a request is pending so counters freeze until the core acks.
    assign match_en = !core_halted && (state_q == REQ_IDLE);

    genvar gi;
    for (gi = 0; gi < NUM_TRIG; gi++) begin : g_trig
        assign addr_we[gi] = wr_en && (sel_idx == 3'(gi)) && !sel_ctrl;
        assign ctrl_we[gi] = wr_en && (sel_idx == 3'(gi)) &&  sel_ctrl;

        rv32i_trig_match #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_trig (
            .clk           (clk),
            .rst_n         (rst_n),
            .addr_we_i     (addr_we[gi]),
            .ctrl_we_i     (ctrl_we[gi]),
            .wdata_i       (apb.pwdata),
            .match_en_i    (match_en),
            .fetch_valid_i (fetch_valid),
            .fetch_pc_i    (fetch_pc),
            .mem_valid_i   (mem_valid),
            .mem_addr_i    (mem_addr),
            .mem_write_i   (mem_write),
            .fire_o        (fire[gi]),
            .addr_o        (trig_addr[gi]),
            .ctrl_o        (trig_ctrl[gi])
        );
    end

    always_comb begin
        rd_word = 32'h0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (sel_idx == 3'(i)) begin
                rd_word = sel_ctrl ? trig_ctrl[i] : trig_addr[i];
            end
        end
    end

    assign apb.prdata  = (access && in_range) ? rd_word : 32'h0;
    assign apb.pslverr = access && !in_range;
    assign apb.pready  = 1'b1;

    // Descending scan leaves the lowest firing index.
    always_comb begin
        fire_idx = 3'd0;
        for (int i = NUM_TRIG - 1; i >= 0; i--) begin
            if (fire[i]) begin
                fire_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hit_idx_d = hit_idx_q;
        case (state_q)
            REQ_IDLE: begin
                if (|fire) begin
                    state_d   = REQ_PEND;
                    hit_idx_d = fire_idx;
                end
            end
            REQ_PEND: begin
                if (halt_ack) begin
                    state_d = REQ_IDLE;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= REQ_IDLE;
            hit_idx_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    assign bp_halt_req   = (state_q == REQ_PEND);
    assign bp_halt_cause = (state_q == REQ_PEND) ? HALT_BREAKPOINT : HALT_NONE;
    assign bp_hit_idx    = hit_idx_q;

endmodule

// File: tb/tb_rv32i_dbg_trigger.sv
// Scoreboard bench for rv32i_dbg_trigger: expectations are queued as stimulus is
// driven and popped against the DUT outputs when they are sampled.
module tb_rv32i_dbg_trigger;

    localparam int NUM_TRIG  = 4;
    localparam int CNT_WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic        core_halted;
    logic        halt_ack;
    logic        bp_halt_req;
    logic [3:0]  bp_halt_cause;
    logic [2:0]  bp_hit_idx;

    rv32i_dbg_trigger_if apb ();

    rv32i_dbg_trigger #(
        .NUM_TRIG  (NUM_TRIG),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .apb           (apb),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_write     (mem_write),
        .core_halted   (core_halted),
        .halt_ack      (halt_ack),
        .bp_halt_req   (bp_halt_req),
        .bp_halt_cause (bp_halt_cause),
        .bp_hit_idx    (bp_hit_idx)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    string       tag_q [$];
    logic [31:0] exp_q [$];
    logic        m_req = 1'b0;
    logic [2:0]  m_idx = 3'd0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: got 0x%08h, want a queued expectation", obs);
        end else begin
            check_val(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic push_req(input string tag);
        sb_push({tag, ".req"},   32'(m_req));
        sb_push({tag, ".cause"}, m_req ? 32'h2 : 32'h0);
        sb_push({tag, ".idx"},   32'(m_idx));
    endtask

    task automatic pop_req();
        sb_pop(32'(bp_halt_req));
        sb_pop(32'(bp_halt_cause));
        sb_pop(32'(bp_hit_idx));
    endtask

    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = addr; apb.pwdata = data;
        @(negedge clk);
        apb.penable = 1'b1;
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        $display("[TB] apb wr 0x%03h <= 0x%08h", addr, data);
    endtask

    task automatic apb_read(input string tag, input logic [11:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = addr;
        @(negedge clk);
        apb.penable = 1'b1;
        sb_push({tag, ".prdata"},  exp_data);
        sb_push({tag, ".pslverr"}, 32'(exp_err));
        sb_push({tag, ".pready"},  32'h1);
        #1;
        $display("[TB] apb rd 0x%03h -> 0x%08h err=%0b", addr, apb.prdata, apb.pslverr);
        sb_pop(apb.prdata);
        sb_pop(32'(apb.pslverr));
        sb_pop(32'(apb.pready));
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] pc,
                            input logic exp_fire, input logic [2:0] exp_idx);
        @(negedge clk);
        fetch_valid = 1'b1; fetch_pc = pc;
        #1;
        push_req({tag, ".N"});
        pop_req();
        @(negedge clk);
        fetch_valid = 1'b0;
        if (exp_fire) begin
            m_req = 1'b1;
            m_idx = exp_idx;
        end
        #1;
        push_req({tag, ".N1"});
        pop_req();
        $display("[TB] fetch %s pc=0x%08h req=%0b idx=%0d", tag, pc, bp_halt_req, bp_hit_idx);
    endtask

    task automatic do_mem(input string tag, input logic [31:0] addr, input logic wr,
                          input logic exp_fire, input logic [2:0] exp_idx);
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = addr; mem_write = wr;
        @(negedge clk);
        mem_valid = 1'b0; mem_write = 1'b0;
        if (exp_fire) begin
            m_req = 1'b1;
            m_idx = exp_idx;
        end
        #1;
        push_req(tag);
        pop_req();
        $display("[TB] mem %s addr=0x%08h wr=%0b req=%0b", tag, addr, wr, bp_halt_req);
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        halt_ack = 1'b1;
        #1;
        push_req({tag, ".hold"});
        pop_req();
        @(negedge clk);
        halt_ack = 1'b0;
        m_req = 1'b0;
        #1;
        push_req({tag, ".done"});
        pop_req();
        $display("[TB] ack %s req=%0b", tag, bp_halt_req);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = 12'h0; apb.pwdata = 32'h0;
        fetch_valid = 1'b0; fetch_pc = 32'h0;
        mem_valid = 1'b0; mem_addr = 32'h0; mem_write = 1'b0;
        core_halted = 1'b0; halt_ack = 1'b0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        push_req("reset");
        sb_push("reset.prdata", 32'h0);
        sb_push("reset.pslverr", 32'h0);
        pop_req();
        sb_pop(apb.prdata);
        sb_pop(32'(apb.pslverr));
        @(negedge clk);
        rst_n = 1'b1;
        apb_read("rst_ctrl0", 12'h104, 32'h0, 1'b0);
        apb_read("rst_addr0", 12'h100, 32'h0, 1'b0);

        // Exact exec breakpoint, halt gating, W1C
        apb_write(12'h100, 32'h0000_0080);
        apb_write(12'h104, 32'h0000_0001);
        apb_read("ex_addr0", 12'h100, 32'h0000_0080, 1'b0);
        core_halted = 1'b1;
        do_fetch("ex_halted", 32'h80, 1'b0, 3'd0);
        core_halted = 1'b0;
        do_fetch("ex_miss", 32'h84, 1'b0, 3'd0);
        do_fetch("ex_hit", 32'h80, 1'b1, 3'd0);
        apb_read("ex_ctrl0_hit", 12'h104, 32'h8000_0001, 1'b0);
        do_ack("ex_ack");
        apb_write(12'h104, 32'h8000_0001);
        apb_read("ex_ctrl0_w1c", 12'h104, 32'h0000_0001, 1'b0);

        // NAPOT range, k = 8
        apb_write(12'h108, 32'h0000_1000);
        apb_write(12'h10C, 32'h0000_0803);
        do_fetch("napot_out", 32'h1100, 1'b0, 3'd0);
        do_fetch("napot_in", 32'h10FC, 1'b1, 3'd1);
        do_ack("napot_ack");
        apb_read("napot_ctrl1", 12'h10C, 32'h8000_0803, 1'b0);
        apb_write(12'h10C, 32'h8000_0803);

        // Hit-count threshold 3
        apb_write(12'h110, 32'h0000_3000);
        apb_write(12'h114, 32'h0003_0001);
        do_fetch("thr_1", 32'h3000, 1'b0, 3'd0);
        do_fetch("thr_2", 32'h3000, 1'b0, 3'd0);
        do_fetch("thr_3", 32'h3000, 1'b1, 3'd2);
        do_ack("thr_ack1");
        do_fetch("thr_4", 32'h3000, 1'b0, 3'd0);
        do_fetch("thr_5", 32'h3000, 1'b0, 3'd0);
        do_fetch("thr_6", 32'h3000, 1'b1, 3'd2);
        do_ack("thr_ack2");
        apb_read("thr_ctrl2", 12'h114, 32'h8003_0001, 1'b0);
        apb_write(12'h114, 32'h8003_0001);

        // Simultaneous fires on trig1 and trig3, then frozen counting while pending
        apb_write(12'h118, 32'h0000_1010);
        apb_write(12'h11C, 32'h0000_0001);
        do_fetch("sim_fire", 32'h1010, 1'b1, 3'd1);
        apb_read("sim_ctrl1", 12'h10C, 32'h8000_0803, 1'b0);
        apb_read("sim_ctrl3", 12'h11C, 32'h8000_0001, 1'b0);
        do_fetch("pend_1", 32'h3000, 1'b0, 3'd0);
        do_fetch("pend_2", 32'h3000, 1'b0, 3'd0);
        do_ack("sim_ack");
        do_fetch("post_1", 32'h3000, 1'b0, 3'd0);
        do_fetch("post_2", 32'h3000, 1'b0, 3'd0);
        do_fetch("post_3", 32'h3000, 1'b1, 3'd2);
        do_ack("post_ack");
        apb_read("post_ctrl2", 12'h114, 32'h8003_0001, 1'b0);

        // Watchpoints
`ifdef RV32I_DBG_WATCHPOINT_EN
        apb_write(12'h100, 32'h0000_2000);
        apb_write(12'h104, 32'h0000_0007);
        apb_read("wp_ctrl0", 12'h104, 32'h0000_0007, 1'b0);
        do_mem("wp_load", 32'h2000, 1'b0, 1'b0, 3'd0);
        do_mem("wp_store", 32'h2000, 1'b1, 1'b1, 3'd0);
        do_ack("wp_ack");
        apb_read("wp_ctrl0_hit", 12'h104, 32'h8000_0007, 1'b0);
        apb_write(12'h104, 32'h8000_0001);
`else
        apb_write(12'h104, 32'h0000_0007);
        apb_read("wp_off_ctrl0", 12'h104, 32'h0000_0003, 1'b0);
        do_mem("wp_off_store", 32'h80, 1'b1, 1'b0, 3'd0);
        apb_write(12'h104, 32'h0000_0001);
`endif

        // APB window errors
        apb_read("err_hi", 12'h120, 32'h0, 1'b1);
        apb_read("err_lo", 12'h0FC, 32'h0, 1'b1);
        apb_write(12'h120, 32'hFFFF_FFFF);
        apb_read("err_last", 12'h11C, 32'h8000_0001, 1'b0);

        // CTRL write colliding with a fire on the same trigger
        apb_write(12'h10C, 32'h0000_0000);
        apb_write(12'h11C, 32'h8002_0001);
        apb_read("col_pre", 12'h11C, 32'h0002_0001, 1'b0);
        do_fetch("col_cnt", 32'h1010, 1'b0, 3'd0);
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = 12'h11C; apb.pwdata = 32'h0002_0001;
        @(negedge clk);
        apb.penable = 1'b1;
        fetch_valid = 1'b1; fetch_pc = 32'h1010;
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        fetch_valid = 1'b0;
        halt_ack = 1'b1;
        @(negedge clk);
        halt_ack = 1'b0;
        m_req = 1'b0;
        $display("[TB] collision write CTRL3 with fetch 0x1010");
        apb_read("col_ctrl3", 12'h11C, 32'h0002_0001, 1'b0);
        do_fetch("col_after1", 32'h1010, 1'b0, 3'd0);
        do_fetch("col_after2", 32'h1010, 1'b1, 3'd3);
        do_ack("col_ack");

        // Asynchronous reset while a request is pending
        do_fetch("rst_f1", 32'h1010, 1'b0, 3'd0);
        do_fetch("rst_f2", 32'h1010, 1'b1, 3'd3);
        #2;
        rst_n = 1'b0;
        m_req = 1'b0;
        m_idx = 3'd0;
        #1;
        push_req("async_rst");
        pop_req();
        $display("[TB] async reset req=%0b", bp_halt_req);
        @(negedge clk);
        rst_n = 1'b1;
        apb_read("rst_ctrl3", 12'h11C, 32'h0, 1'b0);
        apb_read("rst_addr3", 12'h118, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
